// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state type, arbitration mode constants and width helpers shared
// by the memory arbiter and its picker.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational winner selection, lowest index first (fixed) or
// first active port after rr_last (round-robin).
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int  NUM_PORTS = 2,
  parameter int  RR_MODE   = ARB_RR,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_last,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = 0;
    if (RR_MODE == ARB_FIXED) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) winner = IDX_W'(i);
      end
    end else begin
      // Scan from the farthest candidate back so the nearest one after rr_last lands last.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = (int'(rr_last) + k) % NUM_PORTS;
        if (req[idx]) winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter onto one registered memory handshake.
// Defining MEM_ARB_PERF_EN adds per-port grant counters and a wait-cycle counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_PORTS  = 2,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  RR_MODE    = ARB_RR,
  localparam int BE_W       = be_width(DATA_WIDTH),
  localparam int IDX_W      = idx_width(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_read,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]      req_byte_enable,
  output logic [NUM_PORTS-1:0]           req_resp,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [BE_W-1:0]                mem_byte_enable,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic                           mem_resp,
  input  logic [DATA_WIDTH-1:0]          mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]        perf_grants,
  output logic [31:0]                    perf_wait_cycles
`endif
);

  arb_state_t            state, state_next;
  logic [IDX_W-1:0]      grant, rr_last, winner;
  logic                  win_valid, load;
  logic [NUM_PORTS-1:0]  req_any;
  logic [ADDR_WIDTH-1:0] win_address;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [BE_W-1:0]       win_be;
  logic                  win_read, win_write;

  assign req_any     = req_read | req_write;
  assign win_address = req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata   = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign win_be      = req_byte_enable[int'(winner)*BE_W +: BE_W];
  assign win_read    = req_read[winner];
  assign win_write   = req_write[winner];
  assign req_rdata   = mem_rdata;

  rr_picker #(
    .NUM_PORTS(NUM_PORTS),
    .RR_MODE  (RR_MODE)
  ) u_picker (
    .req    (req_any),
    .rr_last(rr_last),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    req_resp   = '0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_next = BUSY;
          load       = 1'b1;
        end
      end
      BUSY: begin
        req_resp[grant] = mem_resp;
        if (mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants only happen from IDLE, so the resp edge always leaves one idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      grant           <= '0;
      rr_last         <= IDX_W'(NUM_PORTS - 1);
    end else if (load) begin
      mem_address     <= win_address;
      mem_wdata       <= win_wdata;
      mem_byte_enable <= win_be;
      mem_write       <= win_write;
      mem_read        <= win_read & ~win_write;
      grant           <= winner;
      rr_last         <= winner;
    end else if (state == BUSY && mem_resp) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
    end
  end

  // A port driving read and write together is a requester bug; it resolves as a write.
  rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    load |-> !(win_read && win_write));

`ifdef MEM_ARB_PERF_EN
  logic [NUM_PORTS-1:0] waiting;

  always_comb begin
    waiting = req_any;
    if (state == BUSY)  waiting[grant]  = 1'b0;
    else if (win_valid) waiting[winner] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants      <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (load && perf_grants[int'(winner)*32 +: 32] != '1)
        perf_grants[int'(winner)*32 +: 32] <= perf_grants[int'(winner)*32 +: 32] + 32'd1;
      if (|waiting && perf_wait_cycles != '1)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench driving a 2-port round-robin, a 2-port fixed
// priority and a 4-port round-robin arbiter against a fixed-latency memory.
module tb_mem_arbiter;

  localparam int NI  = 3;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   rd     [NI];
  logic [3:0]   wr     [NI];
  logic [127:0] addr   [NI];
  logic [127:0] wdata  [NI];
  logic [15:0]  be     [NI];
  logic         mresp  [NI];
  logic [31:0]  mrdata [NI];

  wire  [3:0]   resp_v   [NI];
  wire  [31:0]  rdata_v  [NI];
  wire  [31:0]  maddr_v  [NI];
  wire  [31:0]  mwdata_v [NI];
  wire          mrd_v    [NI];
  wire          mwr_v    [NI];
  wire  [3:0]   mbe_v    [NI];
  wire  [1:0]   resp_a, resp_b;
  wire  [3:0]   resp_c;
`ifdef MEM_ARB_PERF_EN
  wire  [63:0]  pg_a, pg_b;
  wire  [127:0] pg_c;
  wire  [31:0]  pw_a, pw_b, pw_c;
`endif

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_read(rd[0][1:0]), .req_write(wr[0][1:0]),
    .req_address(addr[0][63:0]), .req_wdata(wdata[0][63:0]), .req_byte_enable(be[0][7:0]),
    .req_resp(resp_a), .req_rdata(rdata_v[0]),
    .mem_address(maddr_v[0]), .mem_read(mrd_v[0]), .mem_write(mwr_v[0]),
    .mem_byte_enable(mbe_v[0]), .mem_wdata(mwdata_v[0]),
    .mem_resp(mresp[0]), .mem_rdata(mrdata[0])
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(pg_a), .perf_wait_cycles(pw_a)
`endif
  );

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req_read(rd[1][1:0]), .req_write(wr[1][1:0]),
    .req_address(addr[1][63:0]), .req_wdata(wdata[1][63:0]), .req_byte_enable(be[1][7:0]),
    .req_resp(resp_b), .req_rdata(rdata_v[1]),
    .mem_address(maddr_v[1]), .mem_read(mrd_v[1]), .mem_write(mwr_v[1]),
    .mem_byte_enable(mbe_v[1]), .mem_wdata(mwdata_v[1]),
    .mem_resp(mresp[1]), .mem_rdata(mrdata[1])
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(pg_b), .perf_wait_cycles(pw_b)
`endif
  );

  mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1)) dut_rr4 (
    .clk(clk), .rst_n(rst_n),
    .req_read(rd[2]), .req_write(wr[2]),
    .req_address(addr[2]), .req_wdata(wdata[2]), .req_byte_enable(be[2]),
    .req_resp(resp_c), .req_rdata(rdata_v[2]),
    .mem_address(maddr_v[2]), .mem_read(mrd_v[2]), .mem_write(mwr_v[2]),
    .mem_byte_enable(mbe_v[2]), .mem_wdata(mwdata_v[2]),
    .mem_resp(mresp[2]), .mem_rdata(mrdata[2])
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(pg_c), .perf_wait_cycles(pw_c)
`endif
  );

  assign resp_v[0] = {2'b00, resp_a};
  assign resp_v[1] = {2'b00, resp_b};
  assign resp_v[2] = resp_c;

  // Per-port request records and the memory-side model state.
  logic [31:0] r_addr  [NI][4];
  logic [31:0] r_wdata [NI][4];
  logic [3:0]  r_be    [NI][4];
  logic        r_wr    [NI][4];
  logic [31:0] r_rdv   [NI][4];
  int          reissue [NI][4];
  bit          m_busy  [NI];
  int          m_cnt   [NI];
  int          g_port  [NI];
  logic [31:0] g_addr  [NI];
  int          exp_q   [$];
  int          cur_d;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic issue(input int d, input int p, input bit is_wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b, input logic [31:0] rv);
    r_addr[d][p]  = a;
    r_wdata[d][p] = wd;
    r_be[d][p]    = b;
    r_wr[d][p]    = is_wr;
    r_rdv[d][p]   = rv;
    rd[d][p]      = !is_wr;
    wr[d][p]      = is_wr;
    addr[d][p*32 +: 32]  = a;
    wdata[d][p*32 +: 32] = wd;
    be[d][p*4 +: 4]      = b;
  endtask

  function automatic bit busy_any();
    bit b = 1'b0;
    for (int d = 0; d < NI; d++)
      if (m_busy[d] || mresp[d] || (rd[d] | wr[d]) != 4'b0) b = 1'b1;
    return b;
  endfunction

  task automatic clear_models();
    for (int d = 0; d < NI; d++) begin
      rd[d] = '0; wr[d] = '0; mresp[d] = 1'b0; m_busy[d] = 1'b0; m_cnt[d] = 0;
      for (int p = 0; p < 4; p++) reissue[d][p] = 0;
    end
    exp_q.delete();
  endtask

  // One clock: sample combinational responses at the falling edge, then act
  // just after the rising edge as requesters and memory would.
  task automatic step();
    logic [3:0] rs [NI];
    int p;
    @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      rs[d] = resp_v[d];
      if (mresp[d] || rs[d] != 4'b0)
        check("req_resp", rs[d], (mresp[d] && m_busy[d]) ? (4'b0001 << g_port[d]) : 4'b0000);
      if (mresp[d] && m_busy[d])
        check("req_rdata", rdata_v[d], r_rdv[d][g_port[d]]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) begin
      for (int q = 0; q < 4; q++) begin
        if (rs[d][q]) begin
          rd[d][q] = 1'b0;
          wr[d][q] = 1'b0;
          if (reissue[d][q] > 0) begin
            reissue[d][q]--;
            issue(d, q, r_wr[d][q], r_addr[d][q] + 32'h100, r_wdata[d][q] + 32'd1,
                  r_be[d][q], r_rdv[d][q] + 32'd1);
          end
        end
      end
      if (mresp[d]) begin
        mresp[d] = 1'b0;
        if (m_busy[d]) begin
          m_busy[d] = 1'b0;
          check("idle_gap", {mrd_v[d], mwr_v[d]}, 2'b00);
        end
      end else if (m_busy[d]) begin
        check("mem_hold_addr", maddr_v[d], g_addr[d]);
        check("mem_hold_rw", {mrd_v[d], mwr_v[d]}, {!r_wr[d][g_port[d]], r_wr[d][g_port[d]]});
        m_cnt[d]--;
        if (m_cnt[d] == 0) begin
          mresp[d]  = 1'b1;
          mrdata[d] = r_rdv[d][g_port[d]];
        end
      end else if (mrd_v[d] || mwr_v[d]) begin
        if (exp_q.size() == 0 || d != cur_d) begin
          check("spurious_start", {mrd_v[d], mwr_v[d]}, 2'b00);
        end else begin
          p = exp_q.pop_front();
          g_port[d] = p;
          g_addr[d] = r_addr[d][p];
          m_busy[d] = 1'b1;
          m_cnt[d]  = LAT - 1;
          check("grant_addr", maddr_v[d], r_addr[d][p]);
          check("grant_rw", {mrd_v[d], mwr_v[d]}, {!r_wr[d][p], r_wr[d][p]});
          if (r_wr[d][p]) begin
            check("grant_wdata", mwdata_v[d], r_wdata[d][p]);
            check("grant_be", mbe_v[d], r_be[d][p]);
          end
        end
      end
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy_any()) && n < budget) begin
      step();
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_idle", busy_any(), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cur_d = 0;
    for (int d = 0; d < NI; d++) begin
      addr[d] = '0; wdata[d] = '0; be[d] = '0; mrdata[d] = '0;
    end
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) begin
      check("rst_mem_rw", {mrd_v[d], mwr_v[d]}, 2'b00);
      check("rst_mem_addr", maddr_v[d], 32'h0);
      check("rst_mem_wdata_be", {mwdata_v[d], mbe_v[d]}, 36'h0);
      check("rst_req_resp", resp_v[d], 4'b0);
    end
    rst_n = 1'b1;

    // Single read from port 0.
    cur_d = 0;
    issue(0, 0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF);
    exp_q.push_back(0);
    step();
    check("read_latency", mrd_v[0], 1'b1);
    run(40);

    // Partial write from port 1.
    issue(0, 1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 32'hA5A5_0001);
    exp_q.push_back(1);
    run(40);

    // Stray mem_resp while idle must not produce a response.
    mresp[0] = 1'b1;
    mrdata[0] = 32'hBAD0_BAD0;
    step();
    step();
    check("idle_no_start", {mrd_v[0], mwr_v[0]}, 2'b00);

    // Round-robin: both ports request continuously for four transactions.
    issue(0, 0, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 32'h1111_0000);
    issue(0, 1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h2222_0000);
    reissue[0][0] = 1;
    reissue[0][1] = 1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    run(80);

    // Fixed priority: port 0 keeps winning until it stops requesting.
    cur_d = 1;
    issue(1, 0, 1'b1, 32'h0000_5000, 32'hCAFE_0000, 4'hC, 32'h3333_0000);
    issue(1, 1, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 32'h4444_0000);
    reissue[1][0] = 2;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    run(80);

    // Four ports, rr_last at 3 after reset: ports 1 and 3 go 1 then 3,
    // then ports 0 and 2 wrap around to 0 first.
    cur_d = 2;
    issue(2, 1, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 32'h5555_0000);
    issue(2, 3, 1'b1, 32'h0000_8000, 32'h0F0F_0F0F, 4'b1000, 32'h6666_0000);
    exp_q.push_back(1); exp_q.push_back(3);
    run(60);
    issue(2, 2, 1'b0, 32'h0000_9000, 32'h0, 4'hF, 32'h7777_0000);
    issue(2, 0, 1'b0, 32'h0000_A000, 32'h0, 4'hF, 32'h8888_0000);
    exp_q.push_back(0); exp_q.push_back(2);
    run(60);

    // Reset while busy: outputs clear at once and arbitration restarts at port 0.
    cur_d = 0;
    issue(0, 0, 1'b0, 32'h0000_B000, 32'h0, 4'hF, 32'h9999_0000);
    exp_q.push_back(0);
    step();
    step();
    check("pre_rst_busy", mrd_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rw", {mrd_v[0], mwr_v[0]}, 2'b00);
    check("async_rst_resp", resp_v[0], 4'b0);
    clear_models();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(0, 0, 1'b0, 32'h0000_C000, 32'h0, 4'hF, 32'hAAAA_0000);
    issue(0, 1, 1'b0, 32'h0000_D000, 32'h0, 4'hF, 32'hBBBB_0000);
    exp_q.push_back(0); exp_q.push_back(1);
    step();
    check("post_rst_latency", mrd_v[0], 1'b1);
    run(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
